// File: rtl/checksum_scheduler_pkg.sv
// checksum_scheduler_pkg
//   Shared types and sizes for the register-file checksum scheduler and
//   anything else that talks to the 16x8 value register file (e.g. the
//   7-segment display mux).
//   Contents: AW/DW/DEPTH sizes, hold_left width, scheduler state enum,
//   and a two's-complement helper used to form the checksum.
package checksum_scheduler_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int HW    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Checksum is the value that makes the byte sum of all entries wrap to zero.
  function automatic logic [DW-1:0] twos_complement(input logic [DW-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/checksum_scheduler_if.sv
// checksum_scheduler_if
//   Bundles the user write handshake and the single register-file port.
//   master modport: the scheduler (drives memory port and write ack/stall).
//   slave modport : the user/register-file side.
//   Signals:
//     wr_req/wr_addr/wr_data  user write request (level) with address/data
//     wr_ack                  1-cycle pulse when the write is committed
//     wr_stall                request pending but port owned by the scan
//     mem_we/mem_addr/mem_wdata  register-file write port / shared address
//     mem_rdata               combinational read data for mem_addr
interface checksum_scheduler_if;
  import checksum_scheduler_pkg::*;

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_stall, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_stall, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/checksum_scheduler_sec_tick_gen.sv
// sec_tick_gen
//   Free-running divider producing a one-cycle tick every TICK_DIV clocks
//   while enabled. The counter runs 0..TICK_DIV-1 and ticks on the last
//   value, then wraps to 0. clr has priority and restarts the count.
//   Ports: clk, rst_n (async, active low), clr, en -> tick.
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/checksum_scheduler.sv
// checksum_scheduler
//   Arbitrates the single register-file port between user writes and an
//   internal checksum scan, computes the two's-complement checksum of all
//   DEPTH entries and times the display window for the 7-seg mux.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     bus (master)      user write handshake + register-file port
//     sum_start         checksum request level; rising edge starts a scan
//     busy              high while scanning and in the DONE cycle
//     checksum          last computed checksum (registered)
//     cs_valid          high during the display window
//     hold_left         seconds remaining in the window, 0 outside it
//   Sequence: IDLE -> SCAN (DEPTH cycles) -> DONE (1 cycle) -> HOLD -> IDLE.
module checksum_scheduler
  import checksum_scheduler_pkg::*;
#(
  parameter int HOLD_SECS = 10,
  parameter int TICK_DIV  = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  checksum_scheduler_if.master bus,
  input  logic                 sum_start,
  output logic                 busy,
  output logic [DW-1:0]        checksum,
  output logic                 cs_valid,
  output logic [HW-1:0]        hold_left
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SECS);

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic          cs_valid_q, cs_valid_d;
  logic [HW-1:0] hold_left_q, hold_left_d;
  logic          start_prev_q;

  logic start_edge;
  logic tick;
  logic tick_clr;
  logic tick_en;
  logic wr_grant;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  assign start_edge = sum_start & ~start_prev_q;

  // The port is free in every state except SCAN. Gating with rst_n keeps
  // the register file from being written while reset is held.
  assign wr_grant      = rst_n && bus.wr_req && (state_q != SCAN);
  assign bus.mem_we    = wr_grant;
  assign bus.wr_ack    = wr_grant;
  assign bus.wr_stall  = rst_n && bus.wr_req && (state_q == SCAN);
  assign bus.mem_addr  = !rst_n ? '0 : ((state_q == SCAN) ? idx_q : bus.wr_addr);
  assign bus.mem_wdata = rst_n ? bus.wr_data : '0;

  assign busy      = (state_q == SCAN) || (state_q == DONE);
  assign checksum  = checksum_q;
  assign cs_valid  = cs_valid_q;
  assign hold_left = hold_left_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    checksum_d  = checksum_q;
    cs_valid_d  = cs_valid_q;
    hold_left_d = hold_left_q;
    tick_clr    = 1'b0;
    tick_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = SCAN;
          acc_d   = '0;
          idx_d   = '0;
        end
      end

      SCAN: begin
        acc_d = acc_q + bus.mem_rdata;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end

      DONE: begin
        checksum_d  = twos_complement(acc_q);
        cs_valid_d  = 1'b1;
        hold_left_d = HOLD_INIT;
        tick_clr    = 1'b1;
        state_d     = HOLD;
      end

      HOLD: begin
        tick_en = 1'b1;
        // A new request abandons the current window and rescans at once.
        if (start_edge) begin
          cs_valid_d  = 1'b0;
          hold_left_d = '0;
          acc_d       = '0;
          idx_d       = '0;
          state_d     = SCAN;
        end else if (tick) begin
          if (hold_left_q <= HW'(1)) begin
            hold_left_d = '0;
            cs_valid_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            hold_left_d = hold_left_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      checksum_q   <= '0;
      cs_valid_q   <= 1'b0;
      hold_left_q  <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      checksum_q   <= checksum_d;
      cs_valid_q   <= cs_valid_d;
      hold_left_q  <= hold_left_d;
      start_prev_q <= sum_start;
    end
  end

endmodule

// File: tb/tb_checksum_scheduler.sv
// tb_checksum_scheduler
//   Drives checksum_scheduler (TICK_DIV=4, HOLD_SECS=3) against a behavioural
//   16x8 register file. Write vectors come from a table; checksum requests
//   push the expected checksum onto a queue that is popped when cs_valid rises.
module tb_checksum_scheduler;
  import checksum_scheduler_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sum_start = 1'b0;
  logic          busy;
  logic          cs_valid;
  logic [DW-1:0] checksum;
  logic [HW-1:0] hold_left;

  checksum_scheduler_if bus();

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] expQ   [$];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          expWe;
    logic          expAck;
  } wrVec_t;

  wrVec_t vecs [5];

  always #5 clk = ~clk;

  checksum_scheduler #(
    .HOLD_SECS (3),
    .TICK_DIV  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sum_start (sum_start),
    .busy      (busy),
    .checksum  (checksum),
    .cs_valid  (cs_valid),
    .hold_left (hold_left)
  );

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] modelChecksum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + shadow[i];
    return ~s + 8'd1;
  endfunction

  task automatic applyStimulus(input wrVec_t v);
    @(negedge clk);
    bus.wr_req  = v.req;
    bus.wr_addr = v.addr;
    bus.wr_data = v.data;
    #1;
    if (v.req) shadow[v.addr] = v.data;
  endtask

  task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    #1;
    while (!bus.wr_ack && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.wr_ack) checkOutput("write ack timeout", 32'(bus.wr_ack), 32'd1);
    shadow[a] = d;
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask

  task automatic fillAll(input logic [DW-1:0] d);
    for (int i = 0; i < DEPTH; i++) writeWord(AW'(i), d);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((cs_valid || busy) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (cs_valid || busy) checkOutput("return to idle", 32'({cs_valid, busy}), 32'd0);
  endtask

  // Start a scan; optionally raise a write at SCAN cycle wrAt and expect it
  // to stall until DONE. Returns at the first cycle with cs_valid high.
  task automatic runScan(input logic [DW-1:0] exp, input int wrAt,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int cnt = 0;
    bit busyOk = 1'b1;
    bit stallOk = 1'b1;
    bit ackSeen = 1'b0;
    bit clearNext = 1'b0;
    @(negedge clk);
    sum_start = 1'b1;
    expQ.push_back(exp);
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) sum_start = 1'b0;
      if (clearNext) begin
        bus.wr_req = 1'b0;
        clearNext  = 1'b0;
      end
      if (cnt == wrAt) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wd;
      end
      #1;
      if (cnt == 1) checkOutput("window cleared on scan start", 32'({cs_valid, hold_left}), 32'd0);
      if (cs_valid) break;
      if (!busy) busyOk = 1'b0;
      if (cnt <= DEPTH) begin
        if (bus.wr_req && (!bus.wr_stall || bus.wr_ack || bus.mem_we)) stallOk = 1'b0;
      end else if (bus.wr_req) begin
        checkOutput("write serviced in DONE", 32'({bus.mem_we, bus.wr_ack, bus.wr_stall}), 32'b110);
        ackSeen   = 1'b1;
        clearNext = 1'b1;
      end
    end
    if (clearNext) bus.wr_req = 1'b0;
    checkOutput("scan latency", 32'(cnt), 32'(DEPTH + 2));
    checkOutput("busy through scan", 32'(busyOk), 32'd1);
    if (wrAt > 0) begin
      checkOutput("stall during scan", 32'(stallOk), 32'd1);
      checkOutput("write acked after scan", 32'(ackSeen), 32'd1);
      shadow[wa] = wd;
    end
    if (cs_valid && expQ.size() > 0) begin
      checkOutput("checksum", 32'(checksum), 32'(expQ.pop_front()));
      checkOutput("hold_left at window start", 32'(hold_left), 32'd3);
    end else begin
      checkOutput("checksum valid seen", 32'(cs_valid), 32'd1);
      expQ.delete();
    end
  endtask

  // Called at the first cs_valid cycle; follows the window to its end.
  task automatic checkWindow();
    int high = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      #1;
      if (cs_valid) high++;
      if (k == 4)  checkOutput("hold_left second 2", 32'(hold_left), 32'd2);
      if (k == 8)  checkOutput("hold_left second 1", 32'(hold_left), 32'd1);
      if (k == 12) checkOutput("window end", 32'({cs_valid, busy, hold_left}), 32'd0);
    end
    checkOutput("valid window length", 32'(high), 32'd12);
  endtask

  initial begin
    vecs[0] = '{req: 1'b1, addr: 4'd3,  data: 8'h05, expWe: 1'b1, expAck: 1'b1};
    vecs[1] = '{req: 1'b0, addr: 4'd7,  data: 8'h33, expWe: 1'b0, expAck: 1'b0};
    vecs[2] = '{req: 1'b1, addr: 4'd0,  data: 8'hA5, expWe: 1'b1, expAck: 1'b1};
    vecs[3] = '{req: 1'b1, addr: 4'd15, data: 8'hFF, expWe: 1'b1, expAck: 1'b1};
    vecs[4] = '{req: 1'b0, addr: 4'd9,  data: 8'h11, expWe: 1'b0, expAck: 1'b0};

    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

    // Reset with every input active
    bus.wr_req  = 1'b1;
    bus.wr_addr = 4'd9;
    bus.wr_data = 8'h77;
    sum_start   = 1'b1;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset control outputs",
                32'({bus.mem_we, bus.wr_ack, bus.wr_stall, busy, cs_valid}), 32'd0);
    checkOutput("reset mem_addr/wdata", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    checkOutput("reset checksum/hold_left", 32'({checksum, hold_left}), 32'd0);
    bus.wr_req = 1'b0;
    sum_start  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven writes from IDLE
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("mem_we", 32'(bus.mem_we), 32'(vecs[i].expWe));
      checkOutput("wr_ack", 32'(bus.wr_ack), 32'(vecs[i].expAck));
      checkOutput("mem_addr", 32'(bus.mem_addr), 32'(vecs[i].addr));
      if (vecs[i].req) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(vecs[i].data));
    end
    bus.wr_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mem[3] written", 32'(mem[3]), 32'h05);
    checkOutput("mem[15] written", 32'(mem[15]), 32'hFF);

    // All 0x01 -> 0xF0, then follow the display window
    fillAll(8'h01);
    runScan(8'hF0, 0, 4'd0, 8'h00);
    checkWindow();

    // All 0x10 wraps the sum to zero; restart mid-HOLD
    fillAll(8'h10);
    runScan(8'h00, 0, 4'd0, 8'h00);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("valid mid window", 32'(cs_valid), 32'd1);
    runScan(8'h00, 0, 4'd0, 8'h00);

    // Writes during HOLD do not disturb the checksum
    fillAll(8'h01);
    checkOutput("checksum held across writes", 32'(checksum), 32'h00);
    waitIdle();

    // Write raised at SCAN cycle 5 stalls until DONE
    runScan(8'hF0, 5, 4'd2, 8'h55);
    waitIdle();
    checkOutput("stalled write landed", 32'(mem[2]), 32'h55);

    // Mixed contents from the model
    writeWord(4'd7, 8'hC3);
    writeWord(4'd11, 8'h9A);
    runScan(modelChecksum(), 0, 4'd0, 8'h00);
    waitIdle();

    // Reset during SCAN cycle 8
    @(negedge clk);
    sum_start = 1'b1;
    repeat (8) @(negedge clk);
    sum_start = 1'b0;
    #1;
    checkOutput("scanning before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-scan reset outputs",
                32'({busy, cs_valid, checksum, hold_left, bus.mem_we, bus.wr_stall}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runScan(modelChecksum(), 0, 4'd0, 8'h00);
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
